// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter
//   Round-robin arbiter that shares one WIDTH-bit data register (out_q) among
//   NREQ requesters. A grant lasts up to BURST valid/ready beats, then the
//   arbiter spends one IDLE cycle and re-arbitrates starting after the last owner.
//
// Ports
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester data valid                   [NREQ]
//   req_data   requester i data at [i*WIDTH +: WIDTH]     [NREQ*WIDTH]
//   req_ready  per-requester accept, decoded from state   [NREQ]
//   out_q      shared register, last accepted beat        [WIDTH]
//   out_valid  one-cycle pulse after each accepted beat
//   out_owner  id of current or last owner                [IDW]
//   busy       high while a grant is active
module dff_reg_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      out_q,
  output logic                  out_valid,
  output logic [IDW-1:0]        out_owner,
  output logic                  busy
);

  localparam int BCW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1
  } state_t;

  state_t           state_r;
  logic [IDW-1:0]   rr_ptr_r;
  logic [BCW-1:0]   beat_cnt_r;

  logic [IDW-1:0]   pick_s;
  logic             owner_valid_s;
  logic [WIDTH-1:0] owner_data_s;
  logic [IDW-1:0]   next_rr_s;
  logic             last_beat_s;

  // Round-robin pick: the valid requester at the smallest forward distance from rr_ptr.
  always_comb begin
    int best_d;
    int d;
    best_d = NREQ;
    d      = 0;
    pick_s = '0;
    for (int j = 0; j < NREQ; j++) begin
      d = j - int'(rr_ptr_r);
      if (d < 0) begin
        d = d + NREQ;
      end else begin
        d = d;
      end
      if (req_valid[j] && (d < best_d)) begin
        best_d = d;
        pick_s = IDW'(j);
      end else begin
        best_d = best_d;
      end
    end
  end

  // Owner-side decode: the owner's valid/data, and the ready vector gated by state.
  always_comb begin
    owner_valid_s = 1'b0;
    owner_data_s  = '0;
    req_ready     = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (out_owner == IDW'(j)) begin
        owner_valid_s = req_valid[j];
        owner_data_s  = req_data[j*WIDTH +: WIDTH];
        req_ready[j]  = (state_r == ST_OWN);
      end else begin
        req_ready[j]  = 1'b0;
      end
    end
  end

  // Pointer advance and burst-limit detection for the current owner.
  always_comb begin
    if (int'(out_owner) >= NREQ - 1) begin
      next_rr_s = '0;
    end else begin
      next_rr_s = out_owner + IDW'(1);
    end
    last_beat_s = (int'(beat_cnt_r) == BURST - 1);
  end

  // Arbitration FSM with registered datapath and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= '0;
      beat_cnt_r <= '0;
      out_q      <= '0;
      out_valid  <= 1'b0;
      out_owner  <= '0;
      busy       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (|req_valid) begin
            out_owner  <= pick_s;
            beat_cnt_r <= '0;
            state_r    <= ST_OWN;
            busy       <= 1'b1;
          end else begin
            busy       <= 1'b0;
          end
        end
        ST_OWN: begin
          if (!owner_valid_s) begin
            // Owner withdrew: release without a transfer.
            state_r  <= ST_IDLE;
            busy     <= 1'b0;
            rr_ptr_r <= next_rr_s;
          end else begin
            out_q     <= owner_data_s;
            out_valid <= 1'b1;
            if (last_beat_s) begin
              state_r    <= ST_IDLE;
              busy       <= 1'b0;
              rr_ptr_r   <= next_rr_s;
              beat_cnt_r <= '0;
            end else begin
              beat_cnt_r <= beat_cnt_r + BCW'(1);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
